// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: address width, ACK/NACK bit levels and FSM encoding.
package i2c_pkg;

    localparam int ADDR_W = 7;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_WDATA    = 3'd3;
    localparam logic [2:0] ST_WACK     = 3'd4;
    localparam logic [2:0] ST_RDATA    = 3'd5;
    localparam logic [2:0] ST_RACK     = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    // Bit offset of payload byte idx, byte 0 being the most significant; out-of-range maps to 0.
    function automatic int byte_lsb(input int nbytes, input int idx);
        if (idx >= nbytes) begin
            return 0;
        end
        return (nbytes - 1 - idx) * 8;
    endfunction

endpackage

// File: rtl/i2c_bus_edge.sv
// Samples SCL/SDA once and flags SCL rise/fall plus START/STOP, all combinational against the live inputs.
// No backpressure: strobes are single-cycle and must be consumed on the cycle they appear.
module i2c_bus_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    input  logic sda_oe_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic scl_q;
    logic sda_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_i;
            sda_q <= sda_i;
        end
    end

    assign scl_rise_o = scl_i & ~scl_q;
    assign scl_fall_o = ~scl_i & scl_q;
    assign start_o    = sda_oe_i & scl_i & sda_q & ~sda_i;
    assign stop_o     = sda_oe_i & scl_i & ~sda_q & sda_i;

endmodule

// File: rtl/i2c_target_nbyte.sv
// I2C target with a fixed DATA_BYTES payload: commits a write after the last ACKed byte, streams RD_DATA on reads.
// Bus timing is set by the controller; the only flow control is ACK/NACK on the bus.
module i2c_target_nbyte
    import i2c_pkg::*;
#(
    parameter int DATA_BYTES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       I2C_ADDR,
    input  logic [8*DATA_BYTES-1:0] RD_DATA,
    input  logic                    SCL,
    input  logic                    SDA_OUT,
    input  logic                    SDA_OE,
    output logic                    SDA_IN,
    output logic [8*DATA_BYTES-1:0] WR_DATA,
    output logic                    WR_VALID,
    output logic                    RD_LOAD,
    output logic                    BUSY
);

    localparam int         OFF_W    = (DATA_BYTES > 1) ? $clog2(8 * DATA_BYTES) : 3;
    localparam logic [3:0] NBYTES   = 4'(DATA_BYTES);
    localparam logic [3:0] LAST_IDX = 4'(DATA_BYTES - 1);

    logic scl_rise, scl_fall, start, stop;

    i2c_bus_edge u_edge (
        .clk_i      (clk),
        .rst_i      (rst),
        .scl_i      (SCL),
        .sda_i      (SDA_OUT),
        .sda_oe_i   (SDA_OE),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start),
        .stop_o     (stop)
    );

    logic [2:0]              state_q,    state_d;
    logic [2:0]              bit_cnt_q,  bit_cnt_d;
    logic [3:0]              byte_idx_q, byte_idx_d;
    logic [6:0]              shift_q,    shift_d;
    logic                    rw_q,       rw_d;
    logic                    sda_in_q,   sda_in_d;
    logic                    busy_q,     busy_d;
    logic                    wr_valid_q, wr_valid_d;
    logic                    rd_load_q,  rd_load_d;
    logic [8*DATA_BYTES-1:0] rd_buf_q,   rd_buf_d;
    logic [8*DATA_BYTES-1:0] wr_buf_q,   wr_buf_d;
    logic [8*DATA_BYTES-1:0] wr_data_q,  wr_data_d;

    logic [OFF_W-1:0] byte_off;
    logic [7:0]       rx_byte;
    logic [7:0]       rd_byte;

    assign byte_off = OFF_W'(byte_lsb(DATA_BYTES, int'(byte_idx_q)));
    assign rx_byte  = {shift_q, SDA_OUT};
    assign rd_byte  = rd_buf_q[byte_off +: 8];

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        sda_in_d   = sda_in_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        rd_load_d  = 1'b0;
        rd_buf_d   = rd_buf_q;
        wr_buf_d   = wr_buf_q;
        wr_data_d  = wr_data_q;

        // START outranks STOP and any coincident SCL edge.
        if (start) begin
            state_d    = ST_ADDR;
            bit_cnt_d  = 3'd0;
            byte_idx_d = 4'd0;
            sda_in_d   = NACK;
        end else if (stop) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = 3'd0;
            byte_idx_d = 4'd0;
            sda_in_d   = NACK;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], SDA_OUT};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_q == I2C_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                busy_d  = 1'b1;
                                rw_d    = SDA_OUT;
                                if (SDA_OUT) begin
                                    rd_buf_d  = RD_DATA;
                                    rd_load_d = 1'b1;
                                end
                            end else begin
                                state_d = ST_IGNORE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                // In ACK slots the driven level doubles as the phase: first fall starts the slot, second ends it.
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (sda_in_q == NACK) begin
                            sda_in_d = ACK;
                        end else begin
                            bit_cnt_d  = 3'd0;
                            byte_idx_d = 4'd0;
                            state_d    = rw_q ? ST_RDATA : ST_WDATA;
                            sda_in_d   = rw_q ? rd_byte[7] : NACK;
                        end
                    end
                end
                ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], SDA_OUT};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_idx_q < NBYTES) begin
                                wr_buf_d[byte_off +: 8] = rx_byte;
                                state_d = ST_WACK;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_WACK: begin
                    if (scl_fall) begin
                        if (sda_in_q == NACK) begin
                            sda_in_d = ACK;
                        end else begin
                            sda_in_d   = NACK;
                            state_d    = ST_WDATA;
                            byte_idx_d = byte_idx_q + 4'd1;
                            if (byte_idx_q == LAST_IDX) begin
                                wr_data_d  = wr_buf_q;
                                wr_valid_d = 1'b1;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_RACK;
                        end
                    end else if (scl_fall) begin
                        sda_in_d = rd_byte[3'd7 - bit_cnt_q];
                    end
                end
                ST_RACK: begin
                    if (scl_fall) begin
                        sda_in_d = NACK;
                    end else if (scl_rise) begin
                        if (SDA_OE && (SDA_OUT == ACK)) begin
                            state_d   = ST_RDATA;
                            bit_cnt_d = 3'd0;
                            if (byte_idx_q == LAST_IDX) begin
                                byte_idx_d = 4'd0;
                                rd_buf_d   = RD_DATA;
                                rd_load_d  = 1'b1;
                            end else begin
                                byte_idx_d = byte_idx_q + 4'd1;
                            end
                        end else begin
                            state_d  = ST_IGNORE;
                            sda_in_d = NACK;
                        end
                    end
                end
                ST_IGNORE: sda_in_d = NACK;
                default:   sda_in_d = NACK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            byte_idx_q <= 4'd0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            sda_in_q   <= NACK;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_load_q  <= 1'b0;
            rd_buf_q   <= '0;
            wr_buf_q   <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            sda_in_q   <= sda_in_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            rd_load_q  <= rd_load_d;
            rd_buf_q   <= rd_buf_d;
            wr_buf_q   <= wr_buf_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign SDA_IN   = sda_in_q;
    assign WR_DATA  = wr_data_q;
    assign WR_VALID = wr_valid_q;
    assign RD_LOAD  = rd_load_q;
    assign BUSY     = busy_q;

endmodule

// File: doc/i2c_target_nbyte.md
I2C_TARGET_NBYTE -- requirements
Module: i2c_target_nbyte

Interface
REQ-001 SHALL have parameter: DATA_BYTES, 2, bytes per transfer (1..8).
REQ-002 SHALL have port: clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: I2C_ADDR  in  7  own target address.
REQ-005 SHALL have port: RD_DATA  in  8*DATA_BYTES  data returned on reads, byte 0 = [MSB byte].
REQ-006 SHALL have port: SCL  in  1  bus clock from controller, synchronous to clk.
REQ-007 SHALL have port: SDA_OUT  in  1  controller SDA drive.
REQ-008 SHALL have port: SDA_OE  in  1  1 = controller owns SDA (SDA_OUT valid).
REQ-009 SHALL have port: SDA_IN  out  1  target SDA drive, 1 = released.
REQ-010 SHALL have port: WR_DATA  out  8*DATA_BYTES  last complete write payload.
REQ-011 SHALL have port: WR_VALID  out  1  one-cycle pulse, WR_DATA updated.
REQ-012 SHALL have port: RD_LOAD  out  1  one-cycle pulse, RD_DATA captured.
REQ-013 SHALL have port: BUSY  out  1  high from address match until STOP/abort.

Function
REQ-014 SHALL register SCL and SDA_OUT once; edges = previous vs current sample.
REQ-015 START SHALL be SDA_OUT falling while SCL=1 and SDA_OE=1; STOP SHALL be SDA_OUT rising while SCL=1 and SDA_OE=1.
REQ-016 START SHALL enter ADDR from any state (repeated start), clearing bit and byte counters.
REQ-017 STOP SHALL enter IDLE from any state, release SDA_IN, clear BUSY.
REQ-018 Data bits SHALL be sampled on SCL rise, MSB first; SDA_IN SHALL change only on SCL fall.
REQ-019 States: IDLE, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, IGNORE.
REQ-020 ADDR: after 8th rise, match on [7:1]==I2C_ADDR -> ADDR_ACK, BUSY=1; mismatch -> IGNORE, SDA_IN stays 1.
REQ-021 ACK slots SHALL drive SDA_IN=0 from the SCL fall after bit 8 to the next SCL fall.
REQ-022 Write (R/W=0): ADDR_ACK -> WDATA; each 8-bit byte stored at byte index; index<DATA_BYTES -> ACK, else NACK and IGNORE.
REQ-023 WR_DATA SHALL update and WR_VALID pulse one clk after the SCL fall ending the ACK of byte DATA_BYTES-1; partial writes SHALL leave WR_DATA unchanged.
REQ-024 Read (R/W=1): RD_DATA captured and RD_LOAD pulsed on the clk of ADDR match; bytes driven from the SCL fall ending ADDR_ACK.
REQ-025 RACK: SDA_IN released; controller ACK = SDA_OE=1 and SDA_OUT=0 at SCL rise -> next byte; byte index wraps DATA_BYTES-1 -> 0 with RD_DATA re-captured (RD_LOAD pulse).
REQ-026 NACK or SDA_OE=0 at RACK SCL rise -> IGNORE, SDA_IN=1.
REQ-027 IGNORE SHALL hold SDA_IN=1 until START or STOP.
REQ-028 Simultaneous START and SCL edge: START SHALL win.

Reset
REQ-029 rst=0 at a clk edge SHALL force: state IDLE, SDA_IN=1, WR_DATA=0, WR_VALID=0, RD_LOAD=0, BUSY=0, counters 0, SCL/SDA_OUT samples 1.
REQ-030 Reset mid-transaction SHALL abort without WR_VALID; next activity requires a new START.

Structure
REQ-031 Shared package i2c_pkg SHALL hold state encoding, ADDR_W=7, ACK=0/NACK=1 constants.
REQ-032 Sub-module i2c_bus_edge SHALL provide SCL rise/fall, START and STOP strobes.

Verification
REQ-033 DATA_BYTES=2, I2C_ADDR=7'h2A: START, 0x54, 0xBE, 0xEF, STOP -> three ACKs, WR_DATA=16'hBEEF, one WR_VALID.
REQ-034 RD_DATA=16'h1234, START, 0x55, master ACK, ACK, NACK, STOP -> bytes 0x12, 0x34, 0x12 then release; RD_LOAD twice.
REQ-035 START, 0x56 (addr 0x2B) -> SDA_IN stays 1 throughout, BUSY=0, no pulses.
REQ-036 START, 0x54, 0xAA, repeated START, 0x55 -> WR_DATA unchanged, read of RD_DATA follows.
REQ-037 Write 0x54, 0x11, 0x22, 0x33 -> third data byte NACKed, WR_DATA=16'h1122.
REQ-038 rst=0 after first write data byte -> all outputs reset values, no WR_VALID.
